// File: rtl/lc3_mem_master.sv
// lc3_mem_master: initiator side of the LC-3 MAR/MDR bus.
// Accepts one read/write request at a time and sequences the strobes to the
// memory-and-device unit, returning read data or a write-timeout error on a
// one-cycle response strobe.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = write, 0 = read
//   req_addr/wdata    word address and write data, latched on acceptance
//   rsp_valid/err     completion strobe; err = write timed out
//   rsp_rdata         last read data, held until the next read completes
//   bus_out/bus_oe    value driven onto the system bus and its enable
//   ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en   strobes to the unit (r_w 1 = write)
//   mdr_in            MDR value from the unit, valid while gate_mdr_en = 1
//   dev_ready         unit ready flag
module lc3_mem_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mio_en,
  output logic        r_w,
  output logic        gate_mdr_en,
  input  logic [15:0] mdr_in,
  input  logic        dev_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAR,
    S_WMDR,
    S_WR,
    S_WAIT,
    S_RD,
    S_RGATE,
    S_RSP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [15:0] cnt;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            err_q   <= 1'b0;
          end
        end
        S_WR:    cnt <= '0;
        S_WAIT: begin
          // err_q only set when leaving WAIT without dev_ready
          if (!dev_ready) begin
            if (cnt == CNT_LAST) err_q <= 1'b1;
            else                 cnt   <= cnt + 16'd1;
          end
        end
        S_RGATE: rsp_rdata <= mdr_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    bus_out     = '0;
    bus_oe      = 1'b0;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    gate_mdr_en = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = S_MAR;
      end
      S_MAR: begin
        bus_out = addr_q;
        bus_oe  = 1'b1;
        ld_mar  = 1'b1;
        state_n = we_q ? S_WMDR : S_RD;
      end
      S_WMDR: begin
        bus_out = wdata_q;
        bus_oe  = 1'b1;
        ld_mdr  = 1'b1;
        state_n = S_WR;
      end
      S_WR: begin
        mio_en  = 1'b1;
        r_w     = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (dev_ready || cnt == CNT_LAST) state_n = S_RSP;
      end
      S_RD: begin
        mio_en  = 1'b1;
        ld_mdr  = 1'b1;
        state_n = S_RGATE;
      end
      S_RGATE: begin
        gate_mdr_en = 1'b1;
        state_n     = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
